// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: operand forwarding select, load-use detection,
// per-register long-latency scoreboard, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NRD  = 2,
  parameter int REGW = 5,
  parameter int LAT  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NRD*REGW-1:0]     id_rs,
  input  logic [NRD-1:0]          id_rs_use,
  input  logic                    id_long,
  input  logic [REGW-1:0]         id_long_rd,
  input  logic                    ex_regwr,
  input  logic [REGW-1:0]         ex_rd,
  input  logic                    ex_memrd,
  input  logic                    mem_regwr,
  input  logic [REGW-1:0]         mem_rd,
  input  logic                    mem_busy,
  output logic [2*NRD-1:0]        fwd_sel,
  output logic                    stall,
  output logic [2:0]              stall_cause,
  output logic [(1<<REGW)-1:0]    pending,
  output logic [15:0]             stall_cnt
);

  localparam int NREG = 1 << REGW;
  localparam int CW   = $clog2(LAT + 1);

  logic [CW-1:0]   cnt [NREG];
  logic [REGW-1:0] rs;
  logic            load_use;
  logic            raw;
  logic            waw;
  logic            accept;

  always_comb begin
    rs       = '0;
    load_use = 1'b0;
    raw      = 1'b0;
    fwd_sel  = '0;
    for (int i = 0; i < NRD; i++) begin
      rs = id_rs[i*REGW +: REGW];
      if (id_rs_use[i] && rs != '0) begin
        if (ex_memrd && ex_rd == rs)
          load_use = 1'b1;
        if (cnt[rs] != '0)
          raw = 1'b1;
        if (ex_regwr && ex_rd == rs && !ex_memrd)
          fwd_sel[2*i +: 2] = 2'b01;
        else if (mem_regwr && mem_rd == rs)
          fwd_sel[2*i +: 2] = 2'b10;
      end
    end
  end

  // A count of 1 retires this cycle, so only >1 blocks a new writer
  assign waw = id_long && (cnt[id_long_rd] > CW'(1));

  assign stall_cause = {mem_busy, raw | waw, load_use};
  assign stall       = |stall_cause;
  assign accept      = id_long && !stall && id_long_rd != '0;

  always_comb begin
    pending = '0;
    for (int r = 1; r < NREG; r++)
      pending[r] = (cnt[r] != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (accept && id_long_rd == REGW'(r))
          cnt[r] <= CW'(LAT);
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for the combinational
// decode, hand sequences for scoreboard timing, reset and saturation.
module tb_hazard_scoreboard;

  logic        CLK;
  logic        RST;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_use;
  logic        id_long;
  logic [4:0]  id_long_rd;
  logic        ex_regwr;
  logic [4:0]  ex_rd;
  logic        ex_memrd;
  logic        mem_regwr;
  logic [4:0]  mem_rd;
  logic        mem_busy;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [2:0]  stall_cause;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.NRD(2), .REGW(5), .LAT(4)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_long(id_long), .id_long_rd(id_long_rd),
    .ex_regwr(ex_regwr), .ex_rd(ex_rd), .ex_memrd(ex_memrd),
    .mem_regwr(mem_regwr), .mem_rd(mem_rd), .mem_busy(mem_busy),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cause(stall_cause),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] rs_use;
    logic       exw;
    logic [4:0] exrd;
    logic       exm;
    logic       mw;
    logic [4:0] mrd;
    logic       busy;
    logic [3:0] fwd;
    logic       st;
    logic [2:0] cause;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    id_rs = '0; id_rs_use = '0; id_long = 1'b0; id_long_rd = '0;
    ex_regwr = 1'b0; ex_rd = '0; ex_memrd = 1'b0;
    mem_regwr = 1'b0; mem_rd = '0; mem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    vecs[0]  = '{"fwd_ex_pri",  5'd3, 5'd0, 2'b01, 1, 5'd3, 0, 1, 5'd3, 0, 4'b0001, 0, 3'b000};
    vecs[1]  = '{"fwd_mem",     5'd3, 5'd0, 2'b01, 0, 5'd3, 0, 1, 5'd3, 0, 4'b0010, 0, 3'b000};
    vecs[2]  = '{"fwd_r0",      5'd0, 5'd0, 2'b01, 1, 5'd0, 0, 1, 5'd0, 0, 4'b0000, 0, 3'b000};
    vecs[3]  = '{"fwd_unused",  5'd3, 5'd0, 2'b00, 1, 5'd3, 0, 1, 5'd3, 0, 4'b0000, 0, 3'b000};
    vecs[4]  = '{"fwd_two",     5'd4, 5'd6, 2'b11, 1, 5'd6, 0, 1, 5'd4, 0, 4'b0110, 0, 3'b000};
    vecs[5]  = '{"lu_port1",    5'd0, 5'd5, 2'b10, 1, 5'd5, 1, 0, 5'd0, 0, 4'b0000, 1, 3'b001};
    vecs[6]  = '{"lu_memfwd",   5'd5, 5'd0, 2'b01, 1, 5'd5, 1, 1, 5'd5, 0, 4'b0010, 1, 3'b001};
    vecs[7]  = '{"lu_unused",   5'd0, 5'd5, 2'b00, 1, 5'd5, 1, 0, 5'd0, 0, 4'b0000, 0, 3'b000};
    vecs[8]  = '{"lu_r0",       5'd0, 5'd0, 2'b01, 1, 5'd0, 1, 0, 5'd0, 0, 4'b0000, 0, 3'b000};
    vecs[9]  = '{"busy",        5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 0, 5'd0, 1, 4'b0000, 1, 3'b100};
    vecs[10] = '{"busy_lu",     5'd0, 5'd5, 2'b10, 1, 5'd5, 1, 0, 5'd0, 1, 4'b0000, 1, 3'b101};
    vecs[11] = '{"idle",        5'd9, 5'd8, 2'b11, 0, 5'd9, 0, 0, 5'd8, 0, 4'b0000, 0, 3'b000};

    clr();
    RST = 1'b1;
    #2;
    chk("rst_pending", pending, 32'h0);
    chk("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      id_rs     = {vecs[i].rs1, vecs[i].rs0};
      id_rs_use = vecs[i].rs_use;
      ex_regwr  = vecs[i].exw;
      ex_rd     = vecs[i].exrd;
      ex_memrd  = vecs[i].exm;
      mem_regwr = vecs[i].mw;
      mem_rd    = vecs[i].mrd;
      mem_busy  = vecs[i].busy;
      #1;
      chk({vecs[i].name, "_fwd"}, {28'h0, fwd_sel}, {28'h0, vecs[i].fwd});
      chk({vecs[i].name, "_stall"}, {31'h0, stall}, {31'h0, vecs[i].st});
      chk({vecs[i].name, "_cause"}, {29'h0, stall_cause}, {29'h0, vecs[i].cause});
    end

    // load-use then load advances to MEM/WB
    @(negedge CLK);
    clr();
    ex_regwr = 1'b1; ex_rd = 5'd5; ex_memrd = 1'b1;
    id_rs = {5'd5, 5'd0}; id_rs_use = 2'b10;
    #1;
    chk("lu_seq_stall", {31'h0, stall}, 32'd1);
    chk("lu_seq_cause", {29'h0, stall_cause}, 32'b001);
    step();
    ex_regwr = 1'b0; ex_memrd = 1'b0; ex_rd = 5'd0;
    mem_regwr = 1'b1; mem_rd = 5'd5;
    #1;
    chk("lu_seq_release", {31'h0, stall}, 32'd0);
    chk("lu_seq_fwd", {30'h0, fwd_sel[3:2]}, 32'b10);

    // long op RAW on r7
    step();
    clr();
    id_long = 1'b1; id_long_rd = 5'd7;
    #1;
    chk("raw_issue_stall", {31'h0, stall}, 32'd0);
    step();
    clr();
    id_rs = {5'd0, 5'd7}; id_rs_use = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("raw_pend_%0d", k), {31'h0, pending[7]}, 32'd1);
      chk($sformatf("raw_stall_%0d", k), {31'h0, stall}, 32'd1);
      chk($sformatf("raw_cause_%0d", k), {29'h0, stall_cause}, 32'b010);
      step();
    end
    #1;
    chk("raw_done_pend", {31'h0, pending[7]}, 32'd0);
    chk("raw_done_stall", {31'h0, stall}, 32'd0);

    // WAW blocked at cnt=3,2, accepted at cnt=1
    clr();
    id_long = 1'b1; id_long_rd = 5'd7;
    step();
    clr();
    step();
    id_long = 1'b1; id_long_rd = 5'd7;
    #1;
    chk("waw_cnt3_stall", {31'h0, stall}, 32'd1);
    chk("waw_cnt3_cause", {29'h0, stall_cause}, 32'b010);
    step();
    #1;
    chk("waw_cnt2_stall", {31'h0, stall}, 32'd1);
    step();
    #1;
    chk("waw_cnt1_stall", {31'h0, stall}, 32'd0);
    chk("waw_cnt1_pend", {31'h0, pending[7]}, 32'd1);
    step();
    clr();
    id_rs = {5'd0, 5'd7}; id_rs_use = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("reload_stall_%0d", k), {31'h0, stall}, 32'd1);
      step();
    end
    #1;
    chk("reload_done", {31'h0, stall}, 32'd0);

    // reset mid-flight with r9 pending
    clr();
    id_long = 1'b1; id_long_rd = 5'd9;
    step();
    clr();
    id_rs = {5'd0, 5'd9}; id_rs_use = 2'b01;
    #1;
    chk("mid_pend9", {31'h0, pending[9]}, 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_pending", pending, 32'h0);
    chk("mid_rst_cnt", {16'h0, stall_cnt}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'd0);
    step();
    RST = 1'b0;
    clr();
    id_long = 1'b1; id_long_rd = 5'd9;
    step();
    clr();
    #1;
    chk("post_rst_issue", {31'h0, pending[9]}, 32'd1);
    chk("post_rst_cnt", {16'h0, stall_cnt}, 32'h0);

    // saturation of stall_cnt
    mem_busy = 1'b1;
    repeat (65534) @(posedge CLK);
    @(negedge CLK);
    chk("sat_fffe", {16'h0, stall_cnt}, 32'h0000FFFE);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("sat_ffff", {16'h0, stall_cnt}, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
